rf_port_ctrl: RTL
=================

# rf_port_ctrl

Initiator-side access controller for the 16 x 16-bit register file. It turns read requests with two source addresses, and write-back requests with one destination, into the register array's control lines: one-hot ReadEnable1/ReadEnable2, one-hot WriteReg and the shared D bus. It samples the two read bitlines into a valid/ready response stage. It sits between decode/write-back and the register array, and owns register 0 as hardwired zero.

## Interface
- DATA_W, 16, register and bitline width
- NUM_REGS, 16, registers in the array
- ADDR_W, 4, register address width (log2 NUM_REGS)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-low reset
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted when valid & ready
- rd_addr1  in  ADDR_W  source register 1
- rd_addr2  in  ADDR_W  source register 2
- wr_valid  in  1  write-back request; no backpressure, always taken
- wr_addr  in  ADDR_W  destination register
- wr_data  in  DATA_W  write-back data
- ReadEnable1  out  NUM_REGS  one-hot read select, port 1
- ReadEnable2  out  NUM_REGS  one-hot read select, port 2
- WriteReg  out  NUM_REGS  one-hot write select
- D  out  DATA_W  write data to all registers
- Bitline1  in  DATA_W  resolved read bitline, port 1
- Bitline2  in  DATA_W  resolved read bitline, port 2
- rd_rsp_valid  out  1  response valid
- rd_rsp_ready  in  1  response consumed when valid & ready
- rd_data1  out  DATA_W  read result, port 1
- rd_data2  out  DATA_W  read result, port 2

## Operation
- Two-stage read pipeline:
  - S1 (enable): registered addresses plus s1_valid; ReadEnable1/2 = one-hot(addr) while s1_valid, all-zero otherwise.
  - S2 (response): holds rd_data1/2 and rd_rsp_valid.
- S1 to S2 transfer (sample Bitline1/2) happens when s1_valid and (!rd_rsp_valid or rd_rsp_ready).
- rd_req_ready = !s1_valid or S1 transfers this cycle. This gives full throughput of one request per cycle with no bubbles.
- Stall: S1 holds its addresses and keeps ReadEnable asserted. S2 data stays frozen and is unaffected by later writes.
- Register 0:
  - A read of address 0 returns 0 regardless of the bitline, and ReadEnable bit 0 is still driven.
  - A write to address 0 is dropped: WriteReg[0] is never asserted.
- Write path: on wr_valid, WriteReg = one-hot(wr_addr) and D = wr_data for exactly the next cycle. The array captures on the edge ending that cycle. WriteReg is all-zero otherwise; D holds its last value.
- Back-to-back writes to the same address: both issue in order, and the last one wins.
- Read and write of different registers in the same cycle: independent.
- Reset (rst=0 at an edge), including mid-operation:
  - s1_valid=0, rd_rsp_valid=0, rd_data1/2=0, D=0.
  - ReadEnable1/2=0, WriteReg=0.
  - rd_req_ready=1 after reset.
  - In-flight requests are discarded.

## Timing
- Request accepted at edge N.
- ReadEnable driven during cycle N+1.
- Bitlines sampled at edge N+2, so rd_rsp_valid=1 from cycle N+2. Latency is 2 cycles with no stall.
- Write: wr_valid at edge N puts WriteReg/D up in cycle N+1, and the array updates at edge N+2.
- Read-after-write hazard: a sample at the same edge where the array captures a write to the same register. Behaviour depends on RF_BYPASS_EN (see Configuration).
- All outputs are registered; there are no combinational paths from inputs to outputs except rd_req_ready, which depends on rd_rsp_ready.

## Configuration
- RF_BYPASS_EN defined: at an S1 sample, if WriteReg is active for address A != 0 and an S1 address equals A, that port captures D instead of its bitline. The read then returns the value being written.
- RF_BYPASS_EN undefined: the bitline is always captured, so the pre-write value is returned. Software or the pipeline must insert one bubble.

## Structure
- Package rf_pkg holds:
  - constants RF_DATA_W=16, RF_NUM_REGS=16, RF_ADDR_W=4
  - typedefs rf_addr_t, rf_data_t, rf_onehot_t
- Sub-module rf_decode: ADDR_W to NUM_REGS one-hot decoder with enable input. It is instanced three times (ReadEnable1, ReadEnable2, WriteReg) and provides a zero-suppress option for the write instance.

## Test plan
- Reset then idle: all enables 0, rd_rsp_valid=0, rd_req_ready=1.
- Write 0xBEEF to R5, then read (5,0) two cycles later: rd_data1=0xBEEF, rd_data2=0x0000, rsp 2 cycles after accept.
- Write 0x1234 to R0, then read R0: WriteReg never has bit 0 set; rd_data1=0.
- Write R7=0xA5A5 timed so its WriteReg cycle coincides with the S1 sample of a read of R7:
  - with RF_BYPASS_EN: 0xA5A5
  - without: the old value 0x0000
- Four back-to-back reads with rd_rsp_ready=0 for 3 cycles: one response is held stable, ReadEnable holds the second address, rd_req_ready=0. After release, responses arrive in order with no loss.
- rst=0 asserted while S1 and S2 are both valid: the next cycle has all outputs zero, rd_req_ready=1, and no response emerges.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths, types and the one-hot helper for the register-file access controller.
package rf_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_ADDR_W   = 4;

  typedef logic [RF_ADDR_W-1:0]   rf_addr_t;
  typedef logic [RF_DATA_W-1:0]   rf_data_t;
  typedef logic [RF_NUM_REGS-1:0] rf_onehot_t;

  function automatic rf_onehot_t rf_onehot(input rf_addr_t addr);
    rf_onehot_t sel;
    sel       = '0;
    sel[addr] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/rf_decode.sv
// Address to one-hot select decoder with enable; ZERO_SUPPRESS drops register 0
// so that register 0 can never be selected.
module rf_decode
  import rf_pkg::*;
#(
  parameter bit ZERO_SUPPRESS = 1'b0
) (
  input  logic       en,
  input  rf_addr_t   addr,
  output rf_onehot_t onehot
);

  logic addr_allowed;

  assign addr_allowed = !(ZERO_SUPPRESS && (addr == '0));

  // NOTE: the default before the conditional keeps this purely combinational (no latch).
  always_comb begin
    onehot = '0;
    if (en && addr_allowed) begin
      onehot = rf_onehot(addr);
    end
  end

endmodule

// File: rtl/rf_port_ctrl.sv
// Initiator-side controller for the 16 x 16-bit register file: two-stage read pipeline
// and a registered write-back path. Define RF_BYPASS_EN to forward in-flight write data.
module rf_port_ctrl
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = RF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_req_valid,
  output logic                rd_req_ready,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  input  logic                wr_valid,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [NUM_REGS-1:0] ReadEnable1,
  output logic [NUM_REGS-1:0] ReadEnable2,
  output logic [NUM_REGS-1:0] WriteReg,
  output logic [DATA_W-1:0]   D,
  input  logic [DATA_W-1:0]   Bitline1,
  input  logic [DATA_W-1:0]   Bitline2,
  output logic                rd_rsp_valid,
  input  logic                rd_rsp_ready,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2
);

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr1;
  logic [ADDR_W-1:0] s1_addr2;

  logic              wr_pend;
  logic [ADDR_W-1:0] wr_addr_q;

  logic              s1_xfer;
  logic              rd_accept;
  logic              byp1;
  logic              byp2;
  logic [DATA_W-1:0] cap1;
  logic [DATA_W-1:0] cap2;

  // S1 drains whenever S2 is empty or being consumed, so a new request can enter in the same cycle.
  assign s1_xfer      = s1_valid && (!rd_rsp_valid || rd_rsp_ready);
  assign rd_req_ready = !s1_valid || s1_xfer;
  assign rd_accept    = rd_req_valid && rd_req_ready;

`ifdef RF_BYPASS_EN
  assign byp1 = wr_pend && (wr_addr_q != '0) && (wr_addr_q == s1_addr1);
  assign byp2 = wr_pend && (wr_addr_q != '0) && (wr_addr_q == s1_addr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // Register 0 reads as zero whatever the array drives on the bitline.
  always_comb begin
    cap1 = byp1 ? D : Bitline1;
    cap2 = byp2 ? D : Bitline2;
    if (s1_addr1 == '0) cap1 = '0;
    if (s1_addr2 == '0) cap2 = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_addr1 <= '0;
      s1_addr2 <= '0;
    end else if (rd_accept) begin
      s1_valid <= 1'b1;
      s1_addr1 <= rd_addr1;
      s1_addr2 <= rd_addr2;
    end else if (s1_xfer) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_rsp_valid <= 1'b0;
      rd_data1     <= '0;
      rd_data2     <= '0;
    end else if (s1_xfer) begin
      rd_rsp_valid <= 1'b1;
      rd_data1     <= cap1;
      rd_data2     <= cap2;
    end else if (rd_rsp_ready) begin
      rd_rsp_valid <= 1'b0;
    end
  end

  // D keeps its last value between writes; only the select pulses for one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_pend   <= 1'b0;
      wr_addr_q <= '0;
      D         <= '0;
    end else begin
      wr_pend <= wr_valid;
      if (wr_valid) begin
        wr_addr_q <= wr_addr;
        D         <= wr_data;
      end
    end
  end

  rf_decode #(.ZERO_SUPPRESS(1'b0)) u_dec_rd1 (
    .en     (s1_valid),
    .addr   (s1_addr1),
    .onehot (ReadEnable1)
  );

  rf_decode #(.ZERO_SUPPRESS(1'b0)) u_dec_rd2 (
    .en     (s1_valid),
    .addr   (s1_addr2),
    .onehot (ReadEnable2)
  );

  rf_decode #(.ZERO_SUPPRESS(1'b1)) u_dec_wr (
    .en     (wr_pend),
    .addr   (wr_addr_q),
    .onehot (WriteReg)
  );

endmodule
